// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and parity-type encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: reloads on load and flags the last clock of each bit period.
module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [DIV_W-1:0] divisor,
    output logic             bit_tick
);

    logic [DIV_W-1:0] cnt;

    // A divisor of 0 behaves like 1: the loaded value is the number of clocks left minus one.
    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (load)
            cnt <= (divisor == '0) ? '0 : divisor - 1'b1;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign bit_tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: start, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VALID,
    output logic              DATA_READY,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    input  logic [DIV_W-1:0]  BAUD_DIV,
    output logic              TX_out,
    output logic              BUSY
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              rdy_en_q;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_bit_q, par_bit_d;
    logic              par_en_q, par_en_d;
    logic              stop2_q, stop2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop_idx_q, stop_idx_d;

    logic              load;
    logic [DIV_W-1:0]  load_div;
    logic              bit_tick;
    logic              last_stop;
    logic              accept;
    logic              capture;

    uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .divisor  (load_div),
        .bit_tick (bit_tick)
    );

    // rdy_en_q holds ready low for the first edge after reset is released.
    assign last_stop  = (state_q == STOP) && bit_tick && (stop_idx_q == stop2_q);
    assign DATA_READY = rdy_en_q && ((state_q == IDLE) || last_stop);
    assign accept     = DATA_VALID && DATA_READY;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        sh_d       = sh_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        load       = 1'b0;
        load_div   = div_q;
        capture    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept)
                    capture = 1'b1;
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    tx_d      = sh_q[0];
                    bit_idx_d = '0;
                    load      = 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    load = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        stop_idx_d = 1'b0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Shift so the next data bit is always at sh_q[1] when it is sent.
                        bit_idx_d = bit_idx_q + 1'b1;
                        sh_d      = sh_q >> 1;
                        tx_d      = sh_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                    load       = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        if (accept) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                        tx_d       = 1'b1;
                        load       = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Accepting a word snapshots the whole frame configuration and starts the start bit.
        if (capture) begin
            state_d   = START;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            sh_d      = P_DATA;
            par_bit_d = (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            par_en_d  = PAR_EN;
            stop2_d   = STOP2;
            div_d     = BAUD_DIV;
            load      = 1'b1;
            load_div  = BAUD_DIV;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            rdy_en_q   <= 1'b0;
            sh_q       <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            div_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            rdy_en_q   <= 1'b1;
            sh_q       <= sh_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    assign TX_out = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Scoreboard bench for uart_tx_gen: driver queues expected frames, monitor rebuilds each frame's bit stream.
module tb_uart_tx_gen;

    localparam int DW   = 8;
    localparam int DIVW = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [DW-1:0]   P_DATA;
    logic            DATA_VALID, DATA_READY, PAR_EN, PAR_TYP, STOP2;
    logic [DIVW-1:0] BAUD_DIV;
    logic            TX_out, BUSY;

    logic [4:0]      P_DATA5;
    logic            DATA_VALID5, DATA_READY5, PAR_EN5, PAR_TYP5, STOP2_5;
    logic [DIVW-1:0] BAUD_DIV5;
    logic            TX5, BUSY5;

    uart_tx_gen #(.DATA_W(DW), .DIV_W(DIVW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .BAUD_DIV(BAUD_DIV),
        .TX_out(TX_out), .BUSY(BUSY)
    );

    uart_tx_gen #(.DATA_W(5), .DIV_W(DIVW)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA5), .DATA_VALID(DATA_VALID5), .DATA_READY(DATA_READY5),
        .PAR_EN(PAR_EN5), .PAR_TYP(PAR_TYP5), .STOP2(STOP2_5), .BAUD_DIV(BAUD_DIV5),
        .TX_out(TX5), .BUSY(BUSY5)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          pt;
        logic          s2;
        int            div;
        int            acc;
    } frame_t;

    frame_t exp_q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    bit     mon_en = 1'b0;
    bit     in_frame = 1'b0;
    int     busy_run = 0;
    int     last_run = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer a word, wait for the handshake, then scramble inputs to prove they were captured.
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input logic s2,
                        input int div, input logic hold);
        int n = 0;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; BAUD_DIV = DIVW'(div); DATA_VALID = 1'b1;
        while (DATA_READY !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: DATA_READY actual %b required 1", DATA_READY);
            DATA_VALID = 1'b0;
        end else begin
            exp_q.push_back('{d, pe, pt, s2, div, cyc + 1});
            @(posedge CLK);
            #1;
            P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            STOP2 = 1'($urandom); BAUD_DIV = DIVW'($urandom_range(0, 15));
            if (!hold) DATA_VALID = 1'b0;
            @(negedge CLK);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || BUSY !== 1'b0) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: %0d frames still pending, required 0", exp_q.size());
        end
        @(negedge CLK);
    endtask

    // Monitor: on each start bit pop the next expected frame and check it clock by clock.
    initial begin : monitor
        frame_t f;
        bit     bits[$];
        int     de, len, pos;
        de = 1; len = 0; pos = 0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame) begin
                    if (TX_out === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            n_chk++; n_fail++;
                            $display("FAIL unexpected_start: start bit with no word accepted (cycle %0d)", cyc);
                        end else begin
                            f = exp_q.pop_front();
                            bits.delete();
                            bits.push_back(1'b0);
                            for (int i = 0; i < DW; i++) bits.push_back(f.d[i]);
                            if (f.pe) bits.push_back((^f.d) ^ f.pt);
                            bits.push_back(1'b1);
                            if (f.s2) bits.push_back(1'b1);
                            de  = (f.div == 0) ? 1 : f.div;
                            len = bits.size() * de;
                            pos = 0;
                            in_frame = 1'b1;
                            chkn("start_cycle", cyc, f.acc);
                        end
                    end else begin
                        chk1("idle_tx", TX_out, 1'b1);
                        chk1("idle_busy", BUSY, 1'b0);
                        chk1("idle_ready", DATA_READY, 1'b1);
                    end
                end
                if (in_frame) begin
                    chk1("tx_bit", TX_out, bits[pos / de]);
                    chk1("busy", BUSY, 1'b1);
                    chk1("ready", DATA_READY, pos == len - 1);
                    pos++;
                    if (pos == len) in_frame = 1'b0;
                end
            end
        end
    end

    initial begin : busy_len
        forever begin
            @(negedge CLK);
            if (BUSY === 1'b1) begin
                busy_run++;
            end else begin
                if (busy_run > 0) last_run = busy_run;
                busy_run = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit exp5[8];
        int n;
        RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        BAUD_DIV = 16'd1;
        DATA_VALID5 = 1'b0; P_DATA5 = '0; PAR_EN5 = 1'b0; PAR_TYP5 = 1'b0; STOP2_5 = 1'b0;
        BAUD_DIV5 = 16'd1;

        repeat (3) @(posedge CLK);
        #1;
        chk1("rst_tx", TX_out, 1'b1);
        chk1("rst_busy", BUSY, 1'b0);
        chk1("rst_ready", DATA_READY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        #1 chk1("ready_before_edge", DATA_READY, 1'b0);
        @(posedge CLK);
        #1 chk1("ready_after_release", DATA_READY, 1'b1);
        mon_en = 1'b1;
        @(negedge CLK);

        // Basic frame with even parity
        send(8'hA5, 1'b1, 1'b0, 1'b0, 4, 1'b0);
        wait_idle();
        chkn("busy_len_a5", last_run, 44);

        // Odd parity, two stop bits
        send(8'h01, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        wait_idle();
        chkn("busy_len_odd_stop2", last_run, 24);

        // Back-to-back frames with DATA_VALID held
        send(8'h00, 1'b0, 1'b0, 1'b0, 3, 1'b1);
        send(8'hFF, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        wait_idle();
        chkn("busy_len_b2b", last_run, 60);

        // Configuration changes after acceptance must not disturb the frame
        send(8'h3C, 1'b1, 1'b0, 1'b0, 4, 1'b0);
        BAUD_DIV = 16'd9; PAR_EN = 1'b0;
        wait_idle();
        chkn("busy_len_captured", last_run, 44);

        // Divisor 0 gives 1-clock bits
        send(8'h96, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        wait_idle();
        chkn("busy_len_div0", last_run, 10);

        // Reset during data bit 3 aborts the frame
        mon_en = 1'b0;
        send(8'h07, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        repeat (8) @(negedge CLK);
        chk1("pre_rst_tx", TX_out, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk1("abort_tx", TX_out, 1'b1);
        chk1("abort_busy", BUSY, 1'b0);
        chk1("abort_ready", DATA_READY, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1 chk1("ready_after_abort", DATA_READY, 1'b1);
        exp_q.delete();
        mon_en = 1'b1;
        repeat (20) @(negedge CLK);

        // Random frames, some back-to-back
        for (int i = 0; i < 30; i++) begin
            send(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5),
                 (i < 29) ? 1'($urandom) : 1'b0);
            if (!DATA_VALID) repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        wait_idle();

        // DATA_W = 5 build: start, 1,0,1,0,1, parity 1, stop
        exp5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        P_DATA5 = 5'h15; PAR_EN5 = 1'b1; PAR_TYP5 = 1'b0; STOP2_5 = 1'b0; BAUD_DIV5 = 16'd1;
        DATA_VALID5 = 1'b1;
        n = 0;
        while (DATA_READY5 !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk1("dw5_ready", DATA_READY5, 1'b1);
        @(posedge CLK);
        #1 DATA_VALID5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk1("dw5_bit", TX5, exp5[i]);
            chk1("dw5_busy", BUSY5, 1'b1);
        end
        @(negedge CLK);
        chk1("dw5_idle_tx", TX5, 1'b1);
        chk1("dw5_idle_busy", BUSY5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_gen.md
UART_TX_GEN -- requirements
Module: uart_tx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter DIV_W, default 16, width of the baud divisor input.
REQ-003 SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port P_DATA  input  DATA_W  parallel data word, LSB transmitted first.
REQ-006 SHALL have port DATA_VALID  input  1  word offered.
REQ-007 SHALL have port DATA_READY  output  1  block can accept a word this cycle.
REQ-008 SHALL have port PAR_EN  input  1  parity bit inserted when 1.
REQ-009 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd.
REQ-010 SHALL have port STOP2  input  1  two stop bits when 1, one when 0.
REQ-011 SHALL have port BAUD_DIV  input  DIV_W  clocks per bit; value 0 treated as 1.
REQ-012 SHALL have port TX_out  output  1  serial line, idle high.
REQ-013 SHALL have port BUSY  output  1  frame in progress.

Function
REQ-014 SHALL accept a word on a clock edge where DATA_VALID and DATA_READY are both 1; P_DATA, PAR_EN, PAR_TYP, STOP2 and BAUD_DIV are captured at that edge, and later changes do not affect the frame.
REQ-015 SHALL use FSM states IDLE -> START -> DATA -> PARITY (only if captured PAR_EN = 1) -> STOP -> IDLE.
REQ-016 SHALL register TX_out and BUSY, both changing on the edge after acceptance: TX_out = 0 (start bit), BUSY = 1.
REQ-017 SHALL hold every bit for exactly max(BAUD_DIV,1) clocks, timed by a bit-period counter reloaded at each bit boundary.
REQ-018 SHALL send DATA_W data bits LSB first; a bit index counter runs 0..DATA_W-1, and DATA ends after index DATA_W-1.
REQ-019 SHALL compute the parity bit as XOR of the captured data XOR captured PAR_TYP.
REQ-020 SHALL send 1 stop bit (captured STOP2 = 0) or 2 stop bits (STOP2 = 1), TX_out = 1 for each.
REQ-021 SHALL drive DATA_READY = 1 in IDLE and in the final clock of the final stop bit, and 0 at all other times.
REQ-022 SHALL start the next frame without any idle gap when a word is accepted in the final stop clock: START follows directly and BUSY stays 1.
REQ-023 SHALL, with no accepted word at the end of STOP, return to IDLE: TX_out = 1, BUSY = 0.
REQ-024 SHALL make frame length in clocks (1 + DATA_W + PAR_EN + 1 + STOP2) * max(BAUD_DIV,1).
REQ-025 SHALL ignore DATA_VALID while DATA_READY = 0; no word is queued or dropped silently.

Reset
REQ-026 SHALL, while RST = 1 at a clock edge, force state IDLE, TX_out = 1, BUSY = 0, DATA_READY = 0, and clear all counters; DATA_READY rises on the first edge after RST deasserts.
REQ-027 SHALL abort a frame on reset mid-frame: TX_out = 1 on the next edge, and the partial frame is never resumed.

Structure
REQ-028 SHALL take the FSM state enum (IDLE, START, DATA, PARITY, STOP) and parity-type constants (PAR_EVEN = 0, PAR_ODD = 1) from shared package uart_pkg.
REQ-029 SHALL implement the bit-period counter as sub-module uart_baud_cnt (inputs: load, divisor; output: bit_tick).

Verification
REQ-030 SHALL verify basic frame: DATA_W=8, BAUD_DIV=4, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_out bits 0,1,0,1,0,0,1,0,1,0,1, each 4 clocks; BUSY high for 44 clocks.
REQ-031 SHALL verify odd parity and two stop bits: P_DATA=0x01, PAR_TYP=1, STOP2=1, BAUD_DIV=2 -> parity bit 0, two stop bits; BUSY high for 24 clocks.
REQ-032 SHALL verify back-to-back frames: 0x00 then 0xFF, with DATA_VALID held high, PAR_EN=0, BAUD_DIV=3 -> second start bit immediately follows first stop bit, BUSY never drops, 60 clocks total.
REQ-033 SHALL verify reset mid-frame: RST pulsed for 1 clock during data bit 3 -> TX_out = 1 and BUSY = 0 on the next edge, DATA_READY = 1 one edge after RST falls.
REQ-034 SHALL verify captured configuration: BAUD_DIV changed 4->9 and PAR_EN toggled mid-frame -> current frame unchanged; BAUD_DIV=0 yields 1-clock bits.
REQ-035 SHALL verify DATA_W=5 build: P_DATA=5'h15, PAR_EN=1, PAR_TYP=0 -> data bits 1,0,1,0,1, parity 1.
